// File: rtl/xcore_mem_arbiter.sv
// xcore_mem_arbiter: shares one single-port, 1-cycle-latency synchronous
// memory between NUM_M bus masters. The grant is combinational and is
// decided in the same cycle as the request. Burst lock ownership,
// starvation counters and read-response routing are registered.
// Optional feature macro: XCORE_ARB_RR_EN. When it is defined, base
// priority is round-robin; otherwise it is fixed (lowest index wins).
module xcore_mem_arbiter #(
  parameter int NUM_M      = 3,
  parameter int ADDR_W     = 14,
  parameter int STARVE_LIM = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_M-1:0]        m_req,
  input  logic [NUM_M-1:0]        m_we,
  input  logic [NUM_M-1:0]        m_lock,
  input  logic [4*NUM_M-1:0]      m_be,
  input  logic [ADDR_W*NUM_M-1:0] m_addr,
  input  logic [32*NUM_M-1:0]     m_wdata,
  output logic [NUM_M-1:0]        m_gnt,
  output logic [NUM_M-1:0]        m_rvalid,
  output logic [31:0]             m_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [3:0]              mem_be,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata
);

  localparam int         IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam logic [7:0] LIM   = 8'(STARVE_LIM);

  logic [7:0]       starve_cnt [NUM_M];
  logic [NUM_M-1:0] urgent;
  logic             lock_vld;
  logic [IDX_W-1:0] lock_own;
  logic             gnt_hit;
  logic [IDX_W-1:0] gnt_idx;
  logic [NUM_M-1:0] rvld_p1;
`ifdef XCORE_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr;
  logic             lock_cont;
`endif

  // Grant decision: lock continuation, then the lowest-index urgent master,
  // then base priority. The grant is forced to zero while in reset.
  always_comb begin
    m_gnt   = '0;
    gnt_hit = 1'b0;
    gnt_idx = '0;
    urgent  = '0;
`ifdef XCORE_ARB_RR_EN
    lock_cont = 1'b0;
`endif
    for (int i = 0; i < NUM_M; i++) begin
      urgent[i] = m_req[i] && (starve_cnt[i] == LIM);
    end
    if (!rst) begin
      if (lock_vld && m_req[lock_own]) begin
        gnt_hit = 1'b1;
        gnt_idx = lock_own;
`ifdef XCORE_ARB_RR_EN
        lock_cont = 1'b1;
`endif
      end else if (|urgent) begin
        // Scan downward so that the last hit is the lowest index.
        for (int i = NUM_M - 1; i >= 0; i--) begin
          if (urgent[i]) begin
            gnt_hit = 1'b1;
            gnt_idx = IDX_W'(i);
          end
        end
      end else begin
`ifdef XCORE_ARB_RR_EN
        // Scan offsets downward so that the last hit is closest to rr_ptr.
        for (int k = NUM_M - 1; k >= 0; k--) begin
          if (m_req[(int'(rr_ptr) + k) % NUM_M]) begin
            gnt_hit = 1'b1;
            gnt_idx = IDX_W'((int'(rr_ptr) + k) % NUM_M);
          end
        end
`else
        for (int i = NUM_M - 1; i >= 0; i--) begin
          if (m_req[i]) begin
            gnt_hit = 1'b1;
            gnt_idx = IDX_W'(i);
          end
        end
`endif
      end
      if (gnt_hit) begin
        m_gnt[gnt_idx] = 1'b1;
      end
    end
  end

  // Memory-side mux: OR in the fields of the granted master; the outputs are all zero when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (m_gnt[i]) begin
        mem_we    = mem_we | m_we[i];
        mem_be    = mem_be | m_be[4*i +: 4];
        mem_addr  = mem_addr | m_addr[ADDR_W*i +: ADDR_W];
        mem_wdata = mem_wdata | m_wdata[32*i +: 32];
      end
    end
  end

  assign mem_en   = |m_gnt;
  assign m_rdata  = mem_rdata;
  assign m_rvalid = rvld_p1;

  // ---- stage p0 -> p1: read-response routing follows the memory latency ----
  // Remember which master issued the read so its valid lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvld_p1 <= '0;
    end else begin
      rvld_p1 <= m_gnt & ~m_we;
    end
  end

  // Per-master starvation counters: count denied requests and saturate at the limit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_M; i++) begin
      if (rst) begin
        starve_cnt[i] <= '0;
      end else if (m_req[i] && !m_gnt[i]) begin
        if (starve_cnt[i] != LIM) begin
          starve_cnt[i] <= starve_cnt[i] + 8'd1;
        end
      end else begin
        starve_cnt[i] <= '0;
      end
    end
  end

  // Burst lock: a new locked grant takes ownership; the owner dropping m_req or m_lock releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld <= 1'b0;
      lock_own <= '0;
    end else if (gnt_hit && m_lock[gnt_idx]) begin
      lock_vld <= 1'b1;
      lock_own <= gnt_idx;
    end else if (lock_vld && (!m_req[lock_own] || (m_gnt[lock_own] && !m_lock[lock_own]))) begin
      lock_vld <= 1'b0;
    end
  end

`ifdef XCORE_ARB_RR_EN
  // Round-robin pointer: after a fresh (non-continuation) grant, it moves to the index past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_hit && !lock_cont) begin
      if (gnt_idx == IDX_W'(NUM_M - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= gnt_idx + IDX_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_xcore_mem_arbiter.sv
// Directed testbench for xcore_mem_arbiter with a small behavioural memory.
module tb_xcore_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   m_req, m_we, m_lock;
  logic [11:0]  m_be;
  logic [41:0]  m_addr;
  logic [95:0]  m_wdata;
  logic [2:0]   m_gnt, m_rvalid;
  logic [31:0]  m_rdata;
  logic         mem_en, mem_we;
  logic [3:0]   mem_be;
  logic [13:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];

  xcore_mem_arbiter #(.NUM_M(3), .ADDR_W(14), .STARVE_LIM(8)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_lock(m_lock), .m_be(m_be),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory with 1-cycle read latency and byte-enabled writes
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[5:0]][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[5:0]];
      end
    end
  end

  task automatic drive(input int i, input logic req, input logic we, input logic lk,
                       input logic [3:0] be, input logic [13:0] a, input logic [31:0] d);
    m_req[i] = req;
    m_we[i] = we;
    m_lock[i] = lk;
    m_be[4*i +: 4] = be;
    m_addr[14*i +: 14] = a;
    m_wdata[32*i +: 32] = d;
  endtask

  task automatic clear_all();
    m_req = '0; m_we = '0; m_lock = '0; m_be = '0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 14'h5, 32'h1234_5678);
    drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 14'h10, 32'h0);
    @(negedge clk);
    checks++; if (m_gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt: got %b expected %b", m_gnt, 3'b000); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b expected 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    tick();
    @(negedge clk);
    checks++; if (m_rvalid !== 3'b000) begin errors++; $display("FAIL rst_rvalid: got %b expected %b", m_rvalid, 3'b000); end
    tick();
    rst = 1'b0;
    clear_all();
    @(negedge clk);
    checks++; if (m_gnt !== 3'b000) begin errors++; $display("FAIL idle_gnt: got %b expected %b", m_gnt, 3'b000); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL idle_mem_en: got %b expected 0", mem_en); end
    checks++; if (mem_addr !== 14'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
      errors++; $display("FAIL idle_fields: got addr %h wdata %h be %b expected all zero", mem_addr, mem_wdata, mem_be); end
    tick();
  endtask

  task automatic test_fixed_priority();
    drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 14'h10, 32'h0);
    drive(2, 1'b1, 1'b0, 1'b0, 4'hF, 14'h20, 32'h0);
    @(negedge clk);
    checks++; if (m_gnt !== 3'b010) begin errors++; $display("FAIL fixed_gnt: got %b expected %b", m_gnt, 3'b010); end
    checks++; if (mem_addr !== 14'h10) begin errors++; $display("FAIL fixed_addr: got %h expected %h", mem_addr, 14'h10); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL fixed_en_we: got en %b we %b expected en 1 we 0", mem_en, mem_we); end
    tick();
    clear_all();
    @(negedge clk);
    checks++; if (m_rvalid !== 3'b010) begin errors++; $display("FAIL fixed_rvalid: got %b expected %b", m_rvalid, 3'b010); end
    checks++; if (m_rdata !== 32'hA5A5_0010) begin errors++; $display("FAIL fixed_rdata: got %h expected %h", m_rdata, 32'hA5A5_0010); end
    tick();
    @(negedge clk);
    checks++; if (m_rvalid !== 3'b000) begin errors++; $display("FAIL fixed_rvalid_once: got %b expected %b", m_rvalid, 3'b000); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 14'h11, 32'h0);
    tick();
    clear_all();
    drive(2, 1'b1, 1'b0, 1'b0, 4'hF, 14'h22, 32'h0);
    @(negedge clk);
    checks++; if (m_gnt !== 3'b100) begin errors++; $display("FAIL b2b_gnt2: got %b expected %b", m_gnt, 3'b100); end
    checks++; if (m_rvalid !== 3'b010 || m_rdata !== 32'hA5A5_0011) begin
      errors++; $display("FAIL b2b_first: got rvalid %b rdata %h expected 010 %h", m_rvalid, m_rdata, 32'hA5A5_0011); end
    tick();
    clear_all();
    @(negedge clk);
    checks++; if (m_rvalid !== 3'b100 || m_rdata !== 32'hA5A5_0022) begin
      errors++; $display("FAIL b2b_second: got rvalid %b rdata %h expected 100 %h", m_rvalid, m_rdata, 32'hA5A5_0022); end
    tick();
  endtask

  task automatic test_write();
    drive(0, 1'b1, 1'b1, 1'b0, 4'b0011, 14'h3, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++; if (m_gnt !== 3'b001) begin errors++; $display("FAIL wr_gnt: got %b expected %b", m_gnt, 3'b001); end
    checks++; if (mem_we !== 1'b1 || mem_be !== 4'b0011) begin errors++; $display("FAIL wr_we_be: got we %b be %b expected 1 0011", mem_we, mem_be); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 14'h3) begin
      errors++; $display("FAIL wr_data_addr: got %h @%h expected DEADBEEF @0003", mem_wdata, mem_addr); end
    tick();
    clear_all();
    drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 14'h3, 32'h0);
    @(negedge clk);
    checks++; if (m_rvalid !== 3'b000) begin errors++; $display("FAIL wr_no_rvalid: got %b expected %b", m_rvalid, 3'b000); end
    tick();
    clear_all();
    @(negedge clk);
    checks++; if (m_rvalid !== 3'b010 || m_rdata !== 32'hA5A5_BEEF) begin
      errors++; $display("FAIL wr_readback: got rvalid %b rdata %h expected 010 %h", m_rvalid, m_rdata, 32'hA5A5_BEEF); end
    tick();
  endtask

  task automatic test_starvation();
    logic [2:0] exp;
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 14'h1, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 14'h2, 32'h0);
    for (int c = 1; c <= 10; c++) begin
`ifdef XCORE_ARB_RR_EN
      exp = (c % 2 == 1) ? 3'b001 : 3'b010;
`else
      exp = (c == 9) ? 3'b010 : 3'b001;
`endif
      @(negedge clk);
      checks++; if (m_gnt !== exp) begin errors++; $display("FAIL starve_c%0d: got %b expected %b", c, m_gnt, exp); end
      tick();
    end
    clear_all();
    tick();
  endtask

  task automatic test_lock();
    drive(2, 1'b1, 1'b0, 1'b1, 4'hF, 14'h20, 32'h0);
    @(negedge clk);
    checks++; if (m_gnt !== 3'b100) begin errors++; $display("FAIL lock_take: got %b expected %b", m_gnt, 3'b100); end
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 14'h1, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (m_gnt !== 3'b100) begin errors++; $display("FAIL lock_hold_c%0d: got %b expected %b", c, m_gnt, 3'b100); end
      tick();
    end
    m_lock[2] = 1'b0;
    @(negedge clk);
    checks++; if (m_gnt !== 3'b100) begin errors++; $display("FAIL lock_last: got %b expected %b", m_gnt, 3'b100); end
    tick();
    @(negedge clk);
    checks++; if (m_gnt !== 3'b001) begin errors++; $display("FAIL lock_release: got %b expected %b", m_gnt, 3'b001); end
    tick();
    clear_all();
    tick();
  endtask

  task automatic test_lock_drop();
    drive(2, 1'b1, 1'b0, 1'b1, 4'hF, 14'h20, 32'h0);
    @(negedge clk);
    checks++; if (m_gnt !== 3'b100) begin errors++; $display("FAIL drop_take: got %b expected %b", m_gnt, 3'b100); end
    tick();
    drive(2, 1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b1, 4'hF, 14'h12, 32'h0);
    @(negedge clk);
    checks++; if (m_gnt !== 3'b010) begin errors++; $display("FAIL drop_same_cycle: got %b expected %b", m_gnt, 3'b010); end
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 14'h1, 32'h0);
    @(negedge clk);
    checks++; if (m_gnt !== 3'b010) begin errors++; $display("FAIL drop_new_owner: got %b expected %b", m_gnt, 3'b010); end
    tick();
    m_lock[1] = 1'b0;
    @(negedge clk);
    checks++; if (m_gnt !== 3'b010) begin errors++; $display("FAIL drop_owner_last: got %b expected %b", m_gnt, 3'b010); end
    tick();
    @(negedge clk);
    checks++; if (m_gnt !== 3'b001) begin errors++; $display("FAIL drop_after: got %b expected %b", m_gnt, 3'b001); end
    tick();
    clear_all();
    tick();
  endtask

  task automatic test_reset_mid_read();
    drive(2, 1'b1, 1'b0, 1'b1, 4'hF, 14'h20, 32'h0);
    @(negedge clk);
    checks++; if (m_gnt !== 3'b100) begin errors++; $display("FAIL midrst_take: got %b expected %b", m_gnt, 3'b100); end
    tick();
    rst = 1'b1;
    drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 14'h10, 32'h0);
    @(negedge clk);
    checks++; if (m_gnt !== 3'b000 || mem_en !== 1'b0) begin errors++; $display("FAIL midrst_gnt: got gnt %b en %b expected 000 0", m_gnt, mem_en); end
    tick();
    rst = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 14'h1, 32'h0);
    @(negedge clk);
    checks++; if (m_rvalid !== 3'b000) begin errors++; $display("FAIL midrst_rvalid: got %b expected %b", m_rvalid, 3'b000); end
    checks++; if (m_gnt !== 3'b001) begin errors++; $display("FAIL midrst_lock_dropped: got %b expected %b", m_gnt, 3'b001); end
    tick();
    clear_all();
    tick();
  endtask

  task automatic test_base_priority();
    logic [2:0] seq [6];
`ifdef XCORE_ARB_RR_EN
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 14'h1, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 14'h2, 32'h0);
    drive(2, 1'b1, 1'b0, 1'b0, 4'hF, 14'h4, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (m_gnt !== seq[c]) begin errors++; $display("FAIL base_c%0d: got %b expected %b", c, m_gnt, seq[c]); end
      tick();
    end
    clear_all();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_0000 + 32'(i);
    mem_rdata = '0;
    rst = 1'b1;
    clear_all();
    tick();
    test_reset();
    test_fixed_priority();
    test_back_to_back();
    test_write();
    test_starvation();
    test_lock();
    test_lock_drop();
    test_reset_mid_read();
    test_base_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
